pipe_mux_n: RTL and testbench
=============================

Name: pipe_mux_n

Overview:
- Parametrised successor to the fixed 2/3-input 32-bit datapath muxes.
- N-input, W-bit select mux with a registered output stage and valid/ready handshake on every input and on the output.
- Used where operand/writeback selection must be pipelined and may stall, e.g. the writeback select and forwarding paths of the pipelined core.
- Flags out-of-range select codes instead of driving Z.

Parameters:
- N, 4, number of input channels (2..16).
- W, 32, data width in bits.
- SW, $clog2(N) (minimum 1), select width.
- ECW, 8, width of the out-of-range error counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready.
- sel  in  SW  channel select, sampled every cycle.
- out_data  out  W  registered selected data.
- out_src  out  SW  channel index that produced out_data.
- out_valid  out  1  output holds valid data.
- out_ready  in  1  downstream accepts.
- sel_err  out  1  registered one-cycle pulse: previous cycle had sel >= N.
- err_cnt  out  ECW  saturating count of cycles with sel >= N.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_src=0, out_valid=0, sel_err=0, err_cnt=0, skid empty.
- During reset, in_ready=0 on all channels.
- Accept condition: A = (sel < N) && in_valid[sel] && in_ready[sel].
- in_ready[i] = 0 for every i != sel.
- in_ready[i] = 0 for all i when sel >= N.
- Base mode: in_ready[sel] = !out_valid || out_ready. This is a combinational path from out_ready.
- On A: out_data <= in_data[sel], out_src <= sel, out_valid <= 1 on the next edge. Latency is 1 cycle.
- Output handshake: transfer when out_valid && out_ready.
  - Transfer with no simultaneous A: out_valid <= 0.
  - Transfer with simultaneous A: back-to-back, out_valid stays 1 and data is replaced. Full throughput of 1 word/cycle.
- Stall (out_valid && !out_ready): out_data, out_src and out_valid are held stable. Changing sel during a stall has no effect on the held output.
- sel >= N:
  - No transfer.
  - sel_err <= 1 next cycle, otherwise 0.
  - err_cnt increments, saturating at 2^ECW-1. The counter does not wrap.
  - The output register is unaffected and may still drain.
- Unselected channels are never consumed. Their valid may stay high indefinitely.
- N not a power of 2: codes N..2^SW-1 are errors.
- N a power of 2: error logic is constant 0.
- Reset mid-stall: the held word is discarded and out_valid=0 immediately (async).

Optional Feature:
- Macro PIPE_MUX_SKID_EN.
- When defined:
  - Adds a 1-entry skid buffer.
  - in_ready[sel] = !skid_full, a pure register output with no combinational path from out_ready.
  - A word accepted while the output is stalled goes to skid.
  - On the next output transfer, skid moves to the output and skid_full clears.
  - Ordering is preserved; out_src travels with its data.
  - Throughput remains 1/cycle; latency remains 1 cycle when unstalled.
- When undefined: base mode above; no skid storage is synthesised.

Test Plan:
- Case 1, reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, err_cnt=0 without waiting for a clock edge.
- Case 2, basic accept: N=4, sel=2, in_valid=4'b0100, in_data ch2=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=DEADBEEF, out_src=2. Channels 0, 1 and 3 see in_ready=0.
- Case 3, streaming: sel=1, 8 consecutive words 1..8, out_ready=1 -> 8 output beats in order on consecutive cycles, out_src=1 on each.
- Case 4, stall:
  - Base: out_ready=0 for 3 cycles with sel switched to 3 -> output held at the previous word, in_ready all 0. Release -> ch3 accepted next.
  - PIPE_MUX_SKID_EN: exactly one extra word is absorbed during the stall, then in_ready drops.
- Case 5, error select: N=3, sel=3 held 300 cycles -> sel_err high from cycle 2 onward, err_cnt saturates at 255, no in_ready asserted.
- Case 6, randomized: random valid/ready/sel over 10k cycles -> scoreboard shows no loss, no duplication, and order preserved per accepted stream.

Source files
------------

// File: rtl/pipe_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mux_n
// Description : N-input select mux with registered output, per-channel
//               valid/ready handshake and out-of-range select flagging.
//               Optional 1-entry skid buffer enabled by PIPE_MUX_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mux_n #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int SW  = (N > 1) ? $clog2(N) : 1,
    parameter int ECW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [SW-1:0]    sel,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel_err,
    output logic [ECW-1:0]   err_cnt
);

    localparam int            NPAD      = 1 << SW;
    localparam logic [ECW-1:0] C_ERR_MAX = '1;

    logic [NPAD-1:0] w_valid_pad;
    logic            w_sel_oor;
    logic            w_sel_valid;
    logic [W-1:0]    w_sel_data;
    logic            w_chan_rdy;
    logic            w_out_free;
    logic            w_accept;
    logic [N-1:0]    w_ready;

    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SW-1:0]   out_src_q,   out_src_d;
    logic            out_valid_q, out_valid_d;
    logic            sel_err_q;
    logic [ECW-1:0]  err_cnt_q,   err_cnt_d;

    // Codes N..2^SW-1 only exist when N is not a power of two.
    generate
        if (NPAD == N) begin : g_pow2
            assign w_valid_pad = in_valid;
            assign w_sel_oor   = 1'b0;
        end else begin : g_npow2
            assign w_valid_pad = {{(NPAD-N){1'b0}}, in_valid};
            assign w_sel_oor   = ({{(32-SW){1'b0}}, sel} >= 32'(N));
        end
    endgenerate

    assign w_sel_valid = w_valid_pad[sel];
    assign w_out_free  = !out_valid_q || out_ready;

    always_comb begin
        w_sel_data = '0;
        w_ready    = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                w_sel_data = in_data[i*W +: W];
                w_ready[i] = w_chan_rdy;
            end
        end
    end

    assign in_ready = w_ready & {N{rst_n}};
    assign w_accept = !w_sel_oor && w_sel_valid && w_chan_rdy;

`ifdef PIPE_MUX_SKID_EN
    logic [W-1:0]  skid_data_q, skid_data_d;
    logic [SW-1:0] skid_src_q,  skid_src_d;
    logic          skid_full_q, skid_full_d;

    // Ready comes only from the skid flag, cutting the out_ready path.
    assign w_chan_rdy = !skid_full_q;

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        skid_data_d = skid_data_q;
        skid_src_d  = skid_src_q;
        skid_full_d = skid_full_q;
        if (skid_full_q) begin
            if (w_out_free) begin
                out_data_d  = skid_data_q;
                out_src_d   = skid_src_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end
        end else if (w_accept) begin
            if (w_out_free) begin
                out_data_d  = w_sel_data;
                out_src_d   = sel;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d = w_sel_data;
                skid_src_d  = sel;
                skid_full_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q <= '0;
            skid_src_q  <= '0;
            skid_full_q <= 1'b0;
        end else begin
            skid_data_q <= skid_data_d;
            skid_src_q  <= skid_src_d;
            skid_full_q <= skid_full_d;
        end
    end
`else
    assign w_chan_rdy = w_out_free;

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (w_accept) begin
            out_data_d  = w_sel_data;
            out_src_d   = sel;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (w_sel_oor && (err_cnt_q != C_ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= w_sel_oor;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_mux_n
// Description : Directed and random checks of pipe_mux_n (N=4 and N=3 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mux_n;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;
    localparam int W3 = 8;

    logic           clk = 1'b0;
    logic           rst_n;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_valid;
    logic           out_ready;
    logic           sel_err;
    logic [7:0]     err_cnt;

    logic [3*W3-1:0] in_data3;
    logic [2:0]      in_valid3;
    logic [2:0]      in_ready3;
    logic [1:0]      sel3;
    logic [W3-1:0]   out_data3;
    logic [1:0]      out_src3;
    logic            out_valid3;
    logic            out_ready3;
    logic            sel_err3;
    logic [7:0]      err_cnt3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W+SW-1:0] sb[$];
    logic [W+SW-1:0] exp_word;
    logic            stalled_prev;
    logic [W-1:0]    hold_data;
    logic [SW-1:0]   hold_src;
    logic            prev_oor3;
    logic [N-1:0]    sel_mask;

    always #5 clk = ~clk;

    pipe_mux_n #(.N(N), .W(W), .ECW(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err(sel_err), .err_cnt(err_cnt)
    );

    pipe_mux_n #(.N(3), .W(W3), .ECW(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3),
        .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3),
        .out_ready(out_ready3),
        .sel_err(sel_err3), .err_cnt(err_cnt3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 4'hF;
        sel        = '0;
        out_ready  = 1'b0;
        in_data3   = '0;
        in_valid3  = 3'b111;
        sel3       = '0;
        out_ready3 = 1'b0;

        // Reset state, in_ready gated even with valid high
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_out_src",   out_src, 0);
        chk("rst_sel_err",   sel_err, 0);
        chk("rst_err_cnt",   err_cnt, 0);
        chk("rst_in_ready",  in_ready, 0);
        chk("rst_in_ready3", in_ready3, 0);
        in_valid  = '0;
        in_valid3 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic accept on channel 2
        sel = 2'd2;
        in_valid = 4'b0100;
        in_data[2*W +: W] = 32'hDEADBEEF;
        out_ready = 1'b1;
        #1;
        chk("basic_in_ready", in_ready, 4'b0100);
        tick();
        in_valid = '0;
        chk("basic_valid", out_valid, 1);
        chk("basic_data",  out_data, 32'hDEADBEEF);
        chk("basic_src",   out_src, 2);

        // Streaming 8 words on channel 1
        sel = 2'd1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 4'b0010;
            in_data[1*W +: W] = 32'(i);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data",  out_data, 64'(i));
            chk("stream_src",   out_src, 1);
        end
        in_valid = '0;
        tick();
        chk("stream_drained", out_valid, 0);

        // Stall with select switched to channel 3
        in_valid = 4'b0010;
        in_data[1*W +: W] = 32'h100;
        out_ready = 1'b0;
        tick();
        chk("stall_load", out_data, 32'h100);
        sel = 2'd3;
        in_valid = 4'b1000;
        in_data[3*W +: W] = 32'h300;
        for (int k = 0; k < 3; k++) begin
            #1;
`ifdef PIPE_MUX_SKID_EN
            chk("stall_in_ready", in_ready, (k == 0) ? 4'b1000 : 4'b0000);
`else
            chk("stall_in_ready", in_ready, 4'b0000);
`endif
            tick();
            chk("stall_hold_data",  out_data, 32'h100);
            chk("stall_hold_src",   out_src, 1);
            chk("stall_hold_valid", out_valid, 1);
`ifdef PIPE_MUX_SKID_EN
            if (k == 0) in_data[3*W +: W] = 32'h301;
`endif
        end
        out_ready = 1'b1;
        #1;
`ifdef PIPE_MUX_SKID_EN
        chk("release_in_ready", in_ready, 4'b0000);
`else
        chk("release_in_ready", in_ready, 4'b1000);
`endif
        tick();
        chk("release_data", out_data, 32'h300);
        chk("release_src",  out_src, 3);
`ifdef PIPE_MUX_SKID_EN
        #1;
        chk("skid_reopen", in_ready, 4'b1000);
        tick();
        chk("skid_next_data", out_data, 32'h301);
`endif
        in_valid = '0;
        tick();
        chk("release_drained", out_valid, 0);

        // Out-of-range select on N=3 instance
        sel3 = 2'd3;
        in_valid3 = 3'b111;
        out_ready3 = 1'b1;
        #1;
        chk("oor_in_ready_pre", in_ready3, 0);
        for (int k = 1; k <= 300; k++) begin
            tick();
            chk("oor_sel_err", sel_err3, 1);
            chk("oor_err_cnt", err_cnt3, (k < 255) ? 64'(k) : 64'd255);
            chk("oor_in_ready", in_ready3, 0);
            chk("oor_no_out", out_valid3, 0);
        end
        sel3 = 2'd2;
        in_valid3 = 3'b100;
        in_data3[2*W3 +: W3] = 8'h5A;
        #1;
        chk("n3_in_ready", in_ready3, 3'b100);
        tick();
        in_valid3 = '0;
        chk("n3_sel_err_clear", sel_err3, 0);
        chk("n3_err_cnt_hold",  err_cnt3, 255);
        chk("n3_out_valid",     out_valid3, 1);
        chk("n3_out_data",      out_data3, 8'h5A);
        chk("n3_out_src",       out_src3, 2);
        chk("n4_sel_err",       sel_err, 0);

        // Asynchronous reset during a stall
        sel = 2'd0;
        in_valid = 4'b0001;
        in_data[0 +: W] = 32'hA5;
        out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",    out_valid, 0);
        chk("async_rst_data",     out_data, 0);
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_err_cnt3", err_cnt3, 0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Random traffic with scoreboard
        stalled_prev = 1'b0;
        hold_data    = '0;
        hold_src     = '0;
        prev_oor3    = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
            in_valid   = 4'($urandom);
            sel        = 2'($urandom_range(0, 3));
            out_ready  = ($urandom_range(0, 3) != 0);
            in_data3   = 24'($urandom);
            in_valid3  = 3'($urandom);
            sel3       = 2'($urandom_range(0, 3));
            out_ready3 = 1'($urandom);
            @(negedge clk);
            sel_mask = 4'b0001 << sel;
            chk("rnd_rdy_unsel", in_ready & ~sel_mask, 0);
`ifndef PIPE_MUX_SKID_EN
            chk("rnd_rdy_sel", in_ready[sel], !out_valid || out_ready);
`endif
            if (stalled_prev) begin
                chk("rnd_hold_valid", out_valid, 1);
                chk("rnd_hold_data",  out_data, hold_data);
                chk("rnd_hold_src",   out_src, hold_src);
            end
            if (out_valid && out_ready) begin
                chk("rnd_sb_nonempty", sb.size() == 0, 0);
                if (sb.size() > 0) begin
                    exp_word = sb.pop_front();
                    chk("rnd_out_data", out_data, exp_word[W-1:0]);
                    chk("rnd_out_src",  out_src, exp_word[W+SW-1:W]);
                end
            end
            if (in_valid[sel] && in_ready[sel]) sb.push_back({sel, in_data[sel*W +: W]});
            stalled_prev = out_valid && !out_ready;
            hold_data    = out_data;
            hold_src     = out_src;
            if (sel3 == 2'd3) chk("rnd3_rdy_oor", in_ready3, 0);
            chk("rnd3_sel_err", sel_err3, prev_oor3);
            prev_oor3 = (sel3 == 2'd3);
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("drain_sb_nonempty", sb.size() == 0, 0);
                if (sb.size() > 0) begin
                    exp_word = sb.pop_front();
                    chk("drain_out_data", out_data, exp_word[W-1:0]);
                    chk("drain_out_src",  out_src, exp_word[W+SW-1:W]);
                end
            end
            tick();
        end
        chk("sb_empty", sb.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
